mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the IF stage (instruction reads) and the MEM stage (loads and stores) of the 5-stage pipeline.
- Grants one requester at a time and registers the winning request onto the downstream port.
- Routes the single response back to the owner and produces per-stage stall signals for the pipeline registers.
- Sits between the pipeline stages and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_arb_priority_sel.sv | 22 ++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified memory-port arbiter.
// Optional build macro used by the top: MEM_ARB_PERF_CNT_EN.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } arb_owner_t;

    localparam int PKG_DATA_WIDTH = 64;
    localparam int STRB_WIDTH     = PKG_DATA_WIDTH / 8;

endpackage

// File: rtl/mem_port_arbiter_arb_priority_sel.sv
// Combinational winner selection: MEM has priority unless IF has been
// starved for STARVE_LIMIT consecutive arbitrations.
module arb_priority_sel #(
    parameter int CNT_W        = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             i_if_valid,
    input  logic             i_mem_valid,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_grant_if,
    output logic             o_grant_mem
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic w_at_limit;

    assign w_at_limit  = (i_starve_cnt == LIMIT_C);
    assign o_grant_if  = i_if_valid & (~i_mem_valid | w_at_limit);
    assign o_grant_mem = i_mem_valid & ~o_grant_if;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF fetches and MEM loads/stores, one
// transaction in flight. Optional perf counters: MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_req_ready,
    output logic                    if_resp_valid,
    output logic [DATA_WIDTH-1:0]   if_resp_data,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_wen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
    output logic                    mem_req_ready,
    output logic                    mem_resp_valid,
    output logic [DATA_WIDTH-1:0]   mem_resp_data,
    output logic                    bus_req_valid,
    input  logic                    bus_req_ready,
    output logic                    bus_req_wen,
    output logic [ADDR_WIDTH-1:0]   bus_req_addr,
    output logic [DATA_WIDTH-1:0]   bus_req_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_req_wstrb,
    input  logic                    bus_resp_valid,
    input  logic [DATA_WIDTH-1:0]   bus_resp_data,
    output logic                    stall_if,
    output logic                    stall_mem
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [63:0]             perf_if_grants,
    output logic [63:0]             perf_mem_grants,
    output logic [63:0]             perf_conflict_cycles,
    output logic [63:0]             perf_wait_cycles
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_t             r_state, w_state_next;
    arb_owner_t             r_owner, w_owner_next;
    logic [CNT_W-1:0]       r_starve_cnt, w_starve_next;
    logic                   r_bus_wen;
    logic [ADDR_WIDTH-1:0]  r_bus_addr;
    logic [DATA_WIDTH-1:0]  r_bus_wdata;
    logic [DATA_WIDTH/8-1:0] r_bus_wstrb;

    logic w_grant_if, w_grant_mem, w_idle, w_grant, w_resp_hit;

    arb_priority_sel #(
        .CNT_W        (CNT_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_sel (
        .i_if_valid   (if_req_valid),
        .i_mem_valid  (mem_req_valid),
        .i_starve_cnt (r_starve_cnt),
        .o_grant_if   (w_grant_if),
        .o_grant_mem  (w_grant_mem)
    );

    assign w_idle  = (r_state == IDLE);
    assign w_grant = w_idle & (w_grant_if | w_grant_mem);

    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_starve_next = r_starve_cnt;
        case (r_state)
            IDLE: begin
                if (w_grant_if) begin
                    w_state_next  = ISSUE;
                    w_owner_next  = OWN_IF;
                    w_starve_next = '0;
                end else if (w_grant_mem) begin
                    w_state_next = ISSUE;
                    w_owner_next = OWN_MEM;
                    if (if_req_valid && (r_starve_cnt != LIMIT_C))
                        w_starve_next = r_starve_cnt + 1'b1;
                end
            end
            ISSUE: begin
                if (bus_req_ready)
                    w_state_next = WAIT;
            end
            WAIT: begin
                if (bus_resp_valid) begin
                    w_state_next = IDLE;
                    w_owner_next = OWN_NONE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_owner_next = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // Fields are captured only on the grant edge, so they hold through ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_wen   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
        end else if (w_grant) begin
            if (w_grant_if) begin
                r_bus_wen   <= 1'b0;
                r_bus_addr  <= if_req_addr;
                r_bus_wdata <= '0;
                r_bus_wstrb <= '0;
            end else begin
                r_bus_wen   <= mem_req_wen;
                r_bus_addr  <= mem_req_addr;
                r_bus_wdata <= mem_req_wdata;
                r_bus_wstrb <= mem_req_wstrb;
            end
        end
    end

    assign if_req_ready  = ~rst & w_idle & w_grant_if;
    assign mem_req_ready = ~rst & w_idle & w_grant_mem;

    assign bus_req_valid = (r_state == ISSUE);
    assign bus_req_wen   = r_bus_wen;
    assign bus_req_addr  = r_bus_addr;
    assign bus_req_wdata = r_bus_wdata;
    assign bus_req_wstrb = r_bus_wstrb;

    assign w_resp_hit     = ~rst & (r_state == WAIT) & bus_resp_valid;
    assign if_resp_valid  = w_resp_hit & (r_owner == OWN_IF);
    assign mem_resp_valid = w_resp_hit & (r_owner == OWN_MEM);
    assign if_resp_data   = if_resp_valid ? bus_resp_data : '0;
    assign mem_resp_data  = (mem_resp_valid & ~r_bus_wen) ? bus_resp_data : '0;

    assign stall_if  = if_req_valid & ~if_resp_valid;
    assign stall_mem = mem_req_valid & ~mem_resp_valid;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [63:0] r_perf_if, r_perf_mem, r_perf_conf, r_perf_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_if   <= '0;
            r_perf_mem  <= '0;
            r_perf_conf <= '0;
            r_perf_wait <= '0;
        end else begin
            if (w_idle && w_grant_if)
                r_perf_if <= r_perf_if + 64'd1;
            if (w_idle && w_grant_mem)
                r_perf_mem <= r_perf_mem + 64'd1;
            if (w_idle && if_req_valid && mem_req_valid)
                r_perf_conf <= r_perf_conf + 64'd1;
            if (!w_idle)
                r_perf_wait <= r_perf_wait + 64'd1;
        end
    end

    assign perf_if_grants       = r_perf_if;
    assign perf_mem_grants      = r_perf_mem;
    assign perf_conflict_cycles = r_perf_conf;
    assign perf_wait_cycles     = r_perf_wait;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level arbitration model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [63:0] if_req_addr = '0;
    logic        if_req_ready, if_resp_valid;
    logic [63:0] if_resp_data;
    logic        mem_req_valid = 1'b0, mem_req_wen = 1'b0;
    logic [63:0] mem_req_addr = '0, mem_req_wdata = '0;
    logic [7:0]  mem_req_wstrb = '0;
    logic        mem_req_ready, mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        bus_req_valid, bus_req_wen;
    logic        bus_req_ready = 1'b0;
    logic [63:0] bus_req_addr, bus_req_wdata;
    logic [7:0]  bus_req_wstrb;
    logic        bus_resp_valid = 1'b0;
    logic [63:0] bus_resp_data = '0;
    logic        stall_if, stall_mem;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [63:0] perf_if_grants, perf_mem_grants, perf_conflict_cycles, perf_wait_cycles;
`endif

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wen(bus_req_wen),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
        .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_if_grants(perf_if_grants), .perf_mem_grants(perf_mem_grants),
        .perf_conflict_cycles(perf_conflict_cycles), .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Inputs are driven at posedge+1, combinational outputs read at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Plays the memory side of one granted transaction and reports what it saw.
    task automatic serve(input int rdy_dly, input int rsp_dly, input logic [63:0] rdata,
                         output logic [63:0] o_addr, output logic o_wen,
                         output logic [63:0] o_wdata, output logic [7:0] o_wstrb,
                         output bit o_stable, output int o_lat,
                         output int o_ifp, output int o_memp,
                         output logic [63:0] o_ifd, output logic [63:0] o_memd,
                         output bit o_to);
        o_addr = '0; o_wen = 1'b0; o_wdata = '0; o_wstrb = '0;
        o_stable = 1'b1; o_lat = 0; o_ifp = 0; o_memp = 0; o_ifd = '0; o_memd = '0; o_to = 1'b0;
        tick();
        while (bus_req_valid !== 1'b1 && o_lat < 8) begin
            tick();
            o_lat++;
        end
        if (bus_req_valid !== 1'b1) begin
            o_to = 1'b1;
            return;
        end
        o_addr = bus_req_addr; o_wen = bus_req_wen; o_wdata = bus_req_wdata; o_wstrb = bus_req_wstrb;
        for (int k = 0; k <= rdy_dly; k++) begin
            if (k > 0) tick();
            if (bus_req_valid !== 1'b1 || bus_req_addr !== o_addr || bus_req_wen !== o_wen ||
                bus_req_wdata !== o_wdata || bus_req_wstrb !== o_wstrb)
                o_stable = 1'b0;
            o_ifp  += int'(if_resp_valid);
            o_memp += int'(mem_resp_valid);
        end
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        for (int k = 0; k < rsp_dly; k++) begin
            o_ifp  += int'(if_resp_valid);
            o_memp += int'(mem_resp_valid);
            tick();
        end
        bus_resp_valid = 1'b1;
        bus_resp_data  = rdata;
        settle();
        o_ifp  += int'(if_resp_valid);
        o_memp += int'(mem_resp_valid);
        o_ifd  = if_resp_data;
        o_memd = mem_resp_data;
        tick();
        bus_resp_valid = 1'b0;
        bus_resp_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req_valid = 1'b1; mem_req_valid = 1'b1;
        tick(); tick(); settle();
        checks++; if (if_req_ready !== 1'b0 || mem_req_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready: got if=%b mem=%b want 0 0", if_req_ready, mem_req_ready); end
        checks++; if (bus_req_valid !== 1'b0 || bus_req_wen !== 1'b0) begin errors++;
            $display("FAIL reset_bus_ctl: got valid=%b wen=%b want 0 0", bus_req_valid, bus_req_wen); end
        checks++; if (bus_req_addr !== 64'd0 || bus_req_wdata !== 64'd0 || bus_req_wstrb !== 8'd0) begin errors++;
            $display("FAIL reset_bus_fields: got %h %h %h want 0", bus_req_addr, bus_req_wdata, bus_req_wstrb); end
        checks++; if (if_resp_valid !== 1'b0 || mem_resp_valid !== 1'b0 || if_resp_data !== 64'd0 || mem_resp_data !== 64'd0) begin errors++;
            $display("FAIL reset_resp: got %b %b %h %h want 0", if_resp_valid, mem_resp_valid, if_resp_data, mem_resp_data); end
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        $display("reset: checked idle outputs");
    endtask

    task automatic test_single_fetch();
        logic [63:0] a, wd, ifd, memd; logic w; logic [7:0] ws; bit st, to; int lat, ifp, memp;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
        settle();
        checks++; if (if_req_ready !== 1'b1 || mem_req_ready !== 1'b0) begin errors++;
            $display("FAIL fetch_grant: got if=%b mem=%b want 1 0", if_req_ready, mem_req_ready); end
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_pending: got %b want 1", stall_if); end
        serve(0, 1, 64'h13, a, w, wd, ws, st, lat, ifp, memp, ifd, memd, to);
        checks++; if (to || lat != 0) begin errors++; $display("FAIL fetch_latency: got to=%0d lat=%0d want 0 0", to, lat); end
        checks++; if (a !== 64'h8000_0000 || w !== 1'b0) begin errors++; $display("FAIL fetch_addr: got %h wen=%b want 80000000 0", a, w); end
        checks++; if (ifp != 1 || memp != 0 || ifd !== 64'h13) begin errors++;
            $display("FAIL fetch_resp: got ifp=%0d memp=%0d data=%h want 1 0 13", ifp, memp, ifd); end
        if_req_valid = 1'b0;
        settle();
        checks++; if (stall_if !== 1'b0 || bus_req_valid !== 1'b0) begin errors++;
            $display("FAIL fetch_after: got stall=%b busv=%b want 0 0", stall_if, bus_req_valid); end
        $display("single_fetch: addr=%h data=%h", a, ifd);
    endtask

    task automatic test_conflict();
        logic [63:0] a, wd, ifd, memd; logic w; logic [7:0] ws; bit st, to; int lat, ifp, memp;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0040;
        mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = 64'h8000_1000;
        settle();
        checks++; if (mem_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin errors++;
            $display("FAIL conflict_first: got mem=%b if=%b want 1 0", mem_req_ready, if_req_ready); end
        serve(1, 0, 64'h1122_3344_5566_7788, a, w, wd, ws, st, lat, ifp, memp, ifd, memd, to);
        checks++; if (to || a !== 64'h8000_1000 || memp != 1 || ifp != 0 || memd !== 64'h1122_3344_5566_7788) begin errors++;
            $display("FAIL conflict_mem: got addr=%h memp=%0d ifp=%0d data=%h", a, memp, ifp, memd); end
        mem_req_valid = 1'b0;
        settle();
        checks++; if (if_req_ready !== 1'b1 || stall_if !== 1'b1) begin errors++;
            $display("FAIL conflict_second: got if_ready=%b stall_if=%b want 1 1", if_req_ready, stall_if); end
        serve(0, 0, 64'h6F, a, w, wd, ws, st, lat, ifp, memp, ifd, memd, to);
        checks++; if (to || a !== 64'h8000_0040 || ifp != 1 || ifd !== 64'h6F) begin errors++;
            $display("FAIL conflict_if: got addr=%h ifp=%0d data=%h", a, ifp, ifd); end
        if_req_valid = 1'b0;
        $display("conflict: MEM then IF served");
    endtask

    task automatic test_starvation();
        logic [63:0] a, wd, ifd, memd; logic w; logic [7:0] ws; bit st, to; int lat, ifp, memp;
        int cnt = 0, mem_done = 0, arb = 0, first_if = 0;
        bit exp_if;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_2000;
        mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = 64'h9000_0000;
        while (mem_done < 6 && arb < 12) begin
            arb++;
            exp_if = (cnt == LIMIT);
            cnt = exp_if ? 0 : (cnt < LIMIT ? cnt + 1 : cnt);
            settle();
            checks++; if (if_req_ready !== exp_if || mem_req_ready !== !exp_if) begin errors++;
                $display("FAIL starve_arb%0d: got if=%b mem=%b want if=%b", arb, if_req_ready, mem_req_ready, exp_if); end
            serve(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 64'(arb), a, w, wd, ws, st, lat, ifp, memp, ifd, memd, to);
            checks++; if (to || a !== (exp_if ? if_req_addr : mem_req_addr) || ifp != int'(exp_if) || memp != int'(!exp_if)) begin errors++;
                $display("FAIL starve_txn%0d: got addr=%h ifp=%0d memp=%0d to=%0d", arb, a, ifp, memp, to); end
            $display("starvation: arb=%0d winner=%s addr=%h", arb, exp_if ? "IF" : "MEM", a);
            if (exp_if) begin
                if (first_if == 0) first_if = arb;
                if_req_addr = if_req_addr + 64'd4;
            end else begin
                mem_done++;
                mem_req_addr = mem_req_addr + 64'd8;
            end
        end
        checks++; if (first_if != 5) begin errors++; $display("FAIL starve_first_if: got arb %0d want 5", first_if); end
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
    endtask

    task automatic test_store();
        logic [63:0] a, wd, ifd, memd; logic w; logic [7:0] ws; bit st, to; int lat, ifp, memp;
        mem_req_valid = 1'b1; mem_req_wen = 1'b1; mem_req_addr = 64'h8000_3000;
        mem_req_wdata = 64'hDEAD_BEEF; mem_req_wstrb = 8'h0F;
        settle();
        checks++; if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL store_grant: got %b want 1", mem_req_ready); end
        serve(3, 1, 64'hFFFF_FFFF_FFFF_FFFF, a, w, wd, ws, st, lat, ifp, memp, ifd, memd, to);
        checks++; if (to || !st) begin errors++; $display("FAIL store_stable: got stable=%0d to=%0d want 1 0", st, to); end
        checks++; if (a !== 64'h8000_3000 || w !== 1'b1 || wd !== 64'hDEAD_BEEF || ws !== 8'h0F) begin errors++;
            $display("FAIL store_fields: got %h %b %h %h", a, w, wd, ws); end
        checks++; if (memp != 1 || memd !== 64'd0) begin errors++; $display("FAIL store_ack: got pulses=%0d data=%h want 1 0", memp, memd); end
        mem_req_valid = 1'b0; mem_req_wen = 1'b0; mem_req_wdata = '0; mem_req_wstrb = '0;
        $display("store: addr=%h wdata=%h wstrb=%h", a, wd, ws);
    endtask

    task automatic test_reset_in_wait();
        logic [63:0] a, wd, ifd, memd; logic w; logic [7:0] ws; bit st, to; int lat, ifp, memp;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_4000;
        tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        rst = 1'b1; bus_resp_valid = 1'b1; bus_resp_data = 64'h55;
        settle();
        checks++; if (if_resp_valid !== 1'b0 || if_resp_data !== 64'd0) begin errors++;
            $display("FAIL rst_priority: got pulse=%b data=%h want 0 0", if_resp_valid, if_resp_data); end
        tick();
        rst = 1'b0; if_req_valid = 1'b0;
        settle();
        checks++; if (bus_req_valid !== 1'b0 || bus_req_addr !== 64'd0 || if_resp_valid !== 1'b0 || mem_resp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_late_resp: got busv=%b addr=%h ifr=%b memr=%b", bus_req_valid, bus_req_addr, if_resp_valid, mem_resp_valid); end
        tick();
        bus_resp_valid = 1'b0; bus_resp_data = '0;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_4100;
        settle();
        checks++; if (if_req_ready !== 1'b1 || bus_req_valid !== 1'b0) begin errors++;
            $display("FAIL rst_idle: got ready=%b busv=%b want 1 0", if_req_ready, bus_req_valid); end
        serve(0, 0, 64'h77, a, w, wd, ws, st, lat, ifp, memp, ifd, memd, to);
        checks++; if (to || ifp != 1 || ifd !== 64'h77 || a !== 64'h8000_4100) begin errors++;
            $display("FAIL rst_refetch: got to=%0d ifp=%0d data=%h addr=%h", to, ifp, ifd, a); end
        if_req_valid = 1'b0;
        $display("reset_in_wait: transaction dropped, refetch addr=%h", a);
    endtask

    task automatic test_stray_idle();
        bus_resp_valid = 1'b1; bus_resp_data = 64'($urandom);
        settle();
        checks++; if (if_resp_valid !== 1'b0 || mem_resp_valid !== 1'b0 || if_resp_data !== 64'd0 || mem_resp_data !== 64'd0) begin errors++;
            $display("FAIL stray_resp: got %b %b %h %h want 0", if_resp_valid, mem_resp_valid, if_resp_data, mem_resp_data); end
        tick();
        bus_resp_valid = 1'b0;
        settle();
        checks++; if (bus_req_valid !== 1'b0 || if_req_ready !== 1'b0 || mem_req_ready !== 1'b0 || stall_if !== 1'b0 || stall_mem !== 1'b0) begin errors++;
            $display("FAIL stray_state: got busv=%b rdy=%b%b stall=%b%b", bus_req_valid, if_req_ready, mem_req_ready, stall_if, stall_mem); end
        $display("stray_idle: ignored");
    endtask

    task automatic test_random();
        logic [63:0] a, wd, ifd, memd, rdata; logic w; logic [7:0] ws; bit st, to; int lat, ifp, memp;
        bit if_p = 0, mem_p = 0, exp_if;
        logic [63:0] ia = '0, ma = '0, mwd = '0; logic mw = 1'b0; logic [7:0] ms = '0;
        int cnt = 0, arbs = 0, loops = 0;
        while (arbs < 40 && loops < 200) begin
            loops++;
            if (!if_p && $urandom_range(0, 9) < 6) begin if_p = 1; ia = {32'h8000_0000, $urandom} & ~64'h3; end
            if (!mem_p && $urandom_range(0, 9) < 6) begin
                mem_p = 1; ma = {32'h9000_0000, $urandom}; mw = 1'($urandom);
                mwd = {$urandom, $urandom}; ms = 8'($urandom);
            end
            if_req_valid = if_p; if_req_addr = if_p ? ia : '0;
            mem_req_valid = mem_p; mem_req_addr = mem_p ? ma : '0; mem_req_wen = mem_p & mw;
            mem_req_wdata = mem_p ? mwd : '0; mem_req_wstrb = mem_p ? ms : '0;
            if (!if_p && !mem_p) begin tick(); continue; end
            arbs++;
            exp_if = if_p && (!mem_p || cnt == LIMIT);
            if (exp_if) cnt = 0;
            else if (if_p && cnt < LIMIT) cnt++;
            settle();
            checks++; if (if_req_ready !== exp_if || mem_req_ready !== !exp_if) begin errors++;
                $display("FAIL rand_arb%0d: got if=%b mem=%b want if=%b", arbs, if_req_ready, mem_req_ready, exp_if); end
            rdata = {$urandom, $urandom};
            serve(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rdata, a, w, wd, ws, st, lat, ifp, memp, ifd, memd, to);
            checks++;
            if (to || !st || a !== (exp_if ? ia : ma) || w !== (exp_if ? 1'b0 : mw) ||
                (!exp_if && (wd !== mwd || ws !== ms)) || ifp != int'(exp_if) || memp != int'(!exp_if) ||
                (exp_if && ifd !== rdata) || (!exp_if && memd !== (mw ? 64'd0 : rdata))) begin
                errors++;
                $display("FAIL rand_txn%0d: got addr=%h wen=%b ifp=%0d memp=%0d ifd=%h memd=%h st=%0d to=%0d", arbs, a, w, ifp, memp, ifd, memd, st, to);
            end
            $display("random: arb=%0d winner=%s addr=%h wen=%b rdata=%h", arbs, exp_if ? "IF" : "MEM", a, w, rdata);
            if (exp_if) if_p = 0; else mem_p = 0;
        end
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_conflict();
        test_starvation();
        test_store();
        test_reset_in_wait();
        test_stray_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
